// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one multiplier between NUM_REQ requesters. An in-order
// tag FIFO records who issued each accepted operation so results can be sent back.
module mult_share_arbiter #(
    parameter int DAT_BITS = 256,
    parameter int NUM_REQ  = 2,
    parameter int MAX_OUT  = 8,
    parameter int ID_BITS  = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ*2*DAT_BITS-1:0] i_req_dat,
    input  logic [NUM_REQ-1:0]            i_req_val,
    output logic [NUM_REQ-1:0]            o_req_rdy,
    output logic [2*DAT_BITS-1:0]         o_rsp_dat,
    output logic [NUM_REQ-1:0]            o_rsp_val,
    input  logic [NUM_REQ-1:0]            i_rsp_rdy,
    output logic [DAT_BITS-1:0]           o_mul_dat_a,
    output logic [DAT_BITS-1:0]           o_mul_dat_b,
    output logic                          o_mul_val,
    input  logic                          i_mul_rdy,
    input  logic [2*DAT_BITS-1:0]         i_mul_dat,
    input  logic                          i_mul_val,
    output logic                          o_mul_rdy,
    output logic                          o_err,
    output logic [$clog2(MAX_OUT):0]      o_outstanding
);

    localparam int CNT_BITS = $clog2(MAX_OUT) + 1;
    localparam int PTR_BITS = $clog2(MAX_OUT);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(MAX_OUT);

    logic [ID_BITS-1:0]    rr_q, rr_d, lock_id_q, lock_id_d;
    logic                  lock_q, lock_d, err_q, err_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ID_BITS-1:0]    tag_q [MAX_OUT];
    logic [ID_BITS-1:0]    tag_d [MAX_OUT];
    logic [2*DAT_BITS-1:0] req_word_s [NUM_REQ];
    logic [2*DAT_BITS-1:0] win_word_s;
    logic [ID_BITS-1:0]    win_s, head_s;
    logic                  win_val_s, full_s, empty_s, push_s, pop_s;

    // (base + ofs) mod NUM_REQ, valid while both operands are below NUM_REQ
    function automatic logic [ID_BITS-1:0] rr_add(input logic [ID_BITS-1:0] base,
                                                  input logic [ID_BITS-1:0] ofs);
        logic [ID_BITS:0] sum;
        sum = (ID_BITS+1)'(base) + (ID_BITS+1)'(ofs);
        if (sum >= (ID_BITS+1)'(NUM_REQ)) begin
            sum = sum - (ID_BITS+1)'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return sum[ID_BITS-1:0];
    endfunction

    // split the flat request bus into per-requester {b,a} words
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_word_s[i] = i_req_dat[i*2*DAT_BITS +: 2*DAT_BITS];
        end
    end

    // winner search from the RR pointer; a pending (locked) grant overrides it
    always_comb begin
        logic             found;
        logic [ID_BITS-1:0] idx;
        found = 1'b0;
        idx   = rr_q;
        win_s = rr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx   = rr_add(rr_q, ID_BITS'(i));
            win_s = (!found && i_req_val[idx]) ? idx : win_s;
            found = found | i_req_val[idx];
        end
        win_s      = lock_q ? lock_id_q : win_s;
        win_val_s  = i_req_val[win_s];
        win_word_s = req_word_s[win_s];
    end

    // request/response steering and next-state computation
    always_comb begin
        full_s      = (count_q == FULL_CNT);
        empty_s     = (count_q == {CNT_BITS{1'b0}});
        head_s      = tag_q[rd_ptr_q];
        o_mul_dat_a = win_word_s[DAT_BITS-1:0];
        o_mul_dat_b = win_word_s[2*DAT_BITS-1:DAT_BITS];
        o_mul_val   = !i_rst && win_val_s && !full_s;
        o_req_rdy   = {NUM_REQ{1'b0}};
        o_rsp_val   = {NUM_REQ{1'b0}};
        o_rsp_dat   = i_mul_dat;
        if (!i_rst && !full_s) begin
            o_req_rdy[win_s] = i_mul_rdy;
        end else begin
            o_req_rdy = {NUM_REQ{1'b0}};
        end
        // with nothing outstanding any stray result is accepted and dropped
        if (i_rst) begin
            o_mul_rdy = 1'b0;
        end else if (empty_s) begin
            o_mul_rdy = i_mul_val;
        end else begin
            o_mul_rdy         = i_rsp_rdy[head_s];
            o_rsp_val[head_s] = i_mul_val;
        end
        push_s = o_mul_val && i_mul_rdy;
        pop_s  = i_mul_val && o_mul_rdy && !empty_s;

        tag_d    = tag_q;
        wr_ptr_d = push_s ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
        if (push_s) begin
            tag_d[wr_ptr_q] = win_s;
        end else begin
            tag_d[wr_ptr_q] = tag_q[wr_ptr_q];
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
        rr_d      = push_s ? rr_add(win_s, ID_BITS'(1)) : rr_q;
        lock_d    = push_s ? 1'b0 : ((o_mul_val && !i_mul_rdy) ? 1'b1 : lock_q);
        lock_id_d = (o_mul_val && !i_mul_rdy) ? win_s : lock_id_q;
        err_d     = err_q | (i_mul_val && empty_s);
    end

    // state registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_q      <= {ID_BITS{1'b0}};
            lock_id_q <= {ID_BITS{1'b0}};
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= {CNT_BITS{1'b0}};
            wr_ptr_q  <= {PTR_BITS{1'b0}};
            rd_ptr_q  <= {PTR_BITS{1'b0}};
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_q[i] <= {ID_BITS{1'b0}};
            end
        end else begin
            rr_q      <= rr_d;
            lock_id_q <= lock_id_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign o_err         = err_q;
    assign o_outstanding = count_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed plus randomized bench for mult_share_arbiter; the bench also plays the
// multiplier and keeps an in-order model of issued operations and their products.
module tb_mult_share_arbiter;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int MO = 8;
    localparam int CW = $clog2(MO) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*2*DW-1:0] req_dat;
    logic [NR-1:0]     req_val, req_rdy, rsp_val, rsp_rdy;
    logic [2*DW-1:0]   rsp_dat, mul_d;
    logic [DW-1:0]     mda, mdb;
    logic              mval, mrdy_in, mul_v, mrdy_out, err;
    logic [CW-1:0]     outst;
    logic [DW-1:0]     rqa [NR];
    logic [DW-1:0]     rqb [NR];

    logic [63:0] mq[$];
    logic [63:0] eprod[$];
    int          eid[$];
    int          cnt_exp, lock_id, nxt, e_win, n_pass, n_chk;
    bit          err_exp, out_en, inj_err, e_mval;

    always #5 clk = ~clk;

    assign req_dat = {rqb[1], rqa[1], rqb[0], rqa[0]};

    mult_share_arbiter #(.DAT_BITS(DW), .NUM_REQ(NR), .MAX_OUT(MO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_dat(req_dat), .i_req_val(req_val), .o_req_rdy(req_rdy),
        .o_rsp_dat(rsp_dat), .o_rsp_val(rsp_val), .i_rsp_rdy(rsp_rdy),
        .o_mul_dat_a(mda), .o_mul_dat_b(mdb), .o_mul_val(mval), .i_mul_rdy(mrdy_in),
        .i_mul_dat(mul_d), .i_mul_val(mul_v), .o_mul_rdy(mrdy_out),
        .o_err(err), .o_outstanding(outst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // pending grant first, otherwise first valid requester after the last grant
    function automatic int pick_win();
        if (lock_id >= 0) return lock_id;
        for (int k = 0; k < NR; k++) begin
            if (req_val[(nxt + k) % NR]) return (nxt + k) % NR;
        end
        return -1;
    endfunction

    task automatic raise(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b);
        rqa[r] = a;
        rqb[r] = b;
        req_val[r] = 1'b1;
    endtask

    task automatic settle();
        if (rst) begin
            mul_v = 1'b0; mul_d = '0;
        end else if (inj_err) begin
            mul_v = 1'b1; mul_d = 64'h0bad_0bad_0bad_0bad;
        end else begin
            mul_v = out_en && (mq.size() > 0);
            mul_d = (mq.size() > 0) ? mq[0] : 64'd0;
        end
        #2;
        e_mval = !rst && (req_val != 2'b00) && (cnt_exp < MO);
        e_win  = pick_win();
        chk("mul_val", 64'(mval), 64'(e_mval));
        if (rst) begin
            chk("req_rdy_rst", 64'(req_rdy), 64'd0);
            chk("rsp_val_rst", 64'(rsp_val), 64'd0);
            chk("mul_rdy_rst", 64'(mrdy_out), 64'd0);
        end else begin
            if (req_val != 2'b00) begin
                chk("req_rdy", 64'(req_rdy), (cnt_exp < MO && mrdy_in) ? (64'd1 << e_win) : 64'd0);
                if (e_mval) begin
                    chk("dat_a", 64'(mda), 64'(rqa[e_win]));
                    chk("dat_b", 64'(mdb), 64'(rqb[e_win]));
                end
            end
            if (cnt_exp > 0) begin
                chk("rsp_val", 64'(rsp_val), mul_v ? (64'd1 << eid[0]) : 64'd0);
                chk("mul_rdy", 64'(mrdy_out), 64'(rsp_rdy[eid[0]]));
                if (mul_v) chk("rsp_dat", rsp_dat, eprod[0]);
            end else begin
                chk("rsp_val_empty", 64'(rsp_val), 64'd0);
                chk("mul_rdy_empty", 64'(mrdy_out), 64'(mul_v));
            end
        end
    endtask

    task automatic advance();
        bit push, pop;
        logic [63:0] prod_in;
        push    = e_mval && mrdy_in;
        pop     = 1'b0;
        if (!rst && mul_v && cnt_exp > 0) pop = rsp_rdy[eid[0]];
        prod_in = 64'(mda) * 64'(mdb);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete(); eprod.delete(); eid.delete();
            cnt_exp = 0; err_exp = 1'b0; lock_id = -1; nxt = 0;
        end else begin
            if (mul_v && cnt_exp == 0) err_exp = 1'b1;
            if (pop) begin
                void'(mq.pop_front()); void'(eprod.pop_front()); void'(eid.pop_front());
                cnt_exp--;
            end
            if (push) begin
                mq.push_back(prod_in);
                eprod.push_back(64'(rqa[e_win]) * 64'(rqb[e_win]));
                eid.push_back(e_win);
                cnt_exp++;
                req_val[e_win] = 1'b0;
                lock_id = -1;
                nxt = (e_win + 1) % NR;
            end else if (e_mval && !mrdy_in) begin
                lock_id = e_win;
            end
        end
        chk("outstanding", 64'(outst), 64'(cnt_exp));
        chk("err", 64'(err), 64'(err_exp));
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic drain();
        out_en  = 1'b1;
        rsp_rdy = 2'b11;
        for (int i = 0; i < 40; i++) begin
            if (cnt_exp > 0) step();
        end
        chk("drain", 64'(outst), 64'd0);
    endtask

    initial begin
        n_pass = 0; n_chk = 0; cnt_exp = 0; lock_id = -1; nxt = 0; err_exp = 1'b0;
        rst = 1'b1; req_val = '0; rsp_rdy = 2'b11; mrdy_in = 1'b1; out_en = 1'b0; inj_err = 1'b0;
        rqa[0] = '0; rqa[1] = '0; rqb[0] = '0; rqb[1] = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_outstanding", 64'(outst), 64'd0);

        // fairness: both requesters always pending, grants alternate from 0
        out_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (!req_val[0]) raise(0, 32'(k + 1), 32'(2 * (k + 1)));
            if (!req_val[1]) raise(1, 32'(10 * (k + 1)), 32'(20 * (k + 1)));
            settle();
            chk("fair_grant", 64'(req_rdy), (k % 2 == 1) ? 64'd2 : 64'd1);
            advance();
        end
        req_val = '0;
        drain();

        // single requester round trip
        out_en = 1'b0;
        raise(0, 32'd3, 32'd5);
        settle();
        chk("single_a", 64'(mda), 64'd3);
        chk("single_b", 64'(mdb), 64'd5);
        advance();
        chk("single_cnt1", 64'(outst), 64'd1);
        out_en = 1'b1;
        settle();
        chk("single_rsp_val", 64'(rsp_val), 64'd1);
        chk("single_rsp_dat", rsp_dat, 64'd15);
        advance();
        chk("single_cnt0", 64'(outst), 64'd0);

        // lock: stalled grant to requester 0 survives requester 1 arriving
        mrdy_in = 1'b0;
        raise(0, 32'd7, 32'd9);
        repeat (3) step();
        raise(1, 32'd11, 32'd13);
        settle();
        chk("lock_a", 64'(mda), 64'd7);
        advance();
        mrdy_in = 1'b1;
        settle();
        chk("lock_grant", 64'(req_rdy), 64'd1);
        advance();
        settle();
        chk("lock_next", 64'(req_rdy), 64'd2);
        chk("lock_next_a", 64'(mda), 64'd11);
        advance();
        drain();

        // full: eight outstanding with the multiplier output stalled
        out_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raise(i % 2, 32'(i + 1), 32'd3);
            step();
        end
        chk("full_cnt", 64'(outst), 64'd8);
        raise(0, 32'd100, 32'd2);
        settle();
        chk("full_block", 64'(mval), 64'd0);
        advance();
        out_en = 1'b1;
        settle();
        chk("full_pop_noppush", 64'(mval), 64'd0);
        advance();
        chk("full_cnt7", 64'(outst), 64'd7);
        out_en = 1'b0;
        settle();
        chk("full_retry", 64'(mval), 64'd1);
        advance();
        chk("full_cnt8", 64'(outst), 64'd8);
        drain();

        // response backpressure from the head requester
        out_en = 1'b0;
        raise(1, 32'd6, 32'd7);
        step();
        raise(0, 32'd8, 32'd9);
        step();
        out_en  = 1'b1;
        rsp_rdy = 2'b01;
        repeat (4) begin
            settle();
            chk("bp_hold_val", 64'(rsp_val), 64'd2);
            chk("bp_mul_rdy", 64'(mrdy_out), 64'd0);
            advance();
        end
        rsp_rdy = 2'b11;
        settle();
        chk("bp_rel_dat", rsp_dat, 64'd42);
        advance();
        settle();
        chk("bp_next_val", 64'(rsp_val), 64'd1);
        chk("bp_next_dat", rsp_dat, 64'd72);
        advance();

        // stray result with nothing outstanding
        out_en  = 1'b0;
        inj_err = 1'b1;
        settle();
        chk("err_drain_rdy", 64'(mrdy_out), 64'd1);
        advance();
        inj_err = 1'b0;
        chk("err_set", 64'(err), 64'd1);
        step(); step();
        chk("err_sticky", 64'(err), 64'd1);

        // reset with three outstanding
        for (int i = 0; i < 3; i++) begin
            raise(i % 2, 32'(i + 2), 32'd4);
            step();
        end
        chk("pre_rst_cnt", 64'(outst), 64'd3);
        rst = 1'b1;
        req_val = '0;
        step();
        rst = 1'b0;
        chk("post_rst_cnt", 64'(outst), 64'd0);
        chk("post_rst_err", 64'(err), 64'd0);
        out_en = 1'b1;
        settle();
        chk("post_rst_mval", 64'(mval), 64'd0);
        chk("post_rst_rsp", 64'(rsp_val), 64'd0);
        advance();

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_val[r] && $urandom_range(0, 99) < 55) raise(r, $urandom, $urandom);
            end
            mrdy_in = ($urandom_range(0, 99) < 70);
            out_en  = ($urandom_range(0, 99) < 70);
            rsp_rdy = 2'($urandom);
            step();
        end
        mrdy_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_val != 2'b00) step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
